// File: rtl/pdm_dac_mc.sv
// pdm_dac_mc: multi-channel pulse-density-modulated DAC.
//
// A one-deep holding register accepts a packed sample set through a
// valid/ready handshake. Once per OSR-cycle frame the held set is moved
// into the active registers that feed one modulator per channel. Each
// channel's modulator is either a first-order accumulator (ORDER=1) or a
// second-order saturating two-integrator loop (ORDER=2).
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   din        in   CHANNELS*DATA_BITS packed samples, channel k at [k*DATA_BITS +: DATA_BITS]
//   din_valid  in   din holds a sample set
//   din_ready  out  holding register empty
//   enable     in   modulators run when high
//   dout       out  CHANNELS registered PDM bit streams
//   underrun   out  one-cycle pulse on a frame boundary with no pending sample
module pdm_dac_mc #(
    parameter int DATA_BITS = 12,
    parameter int CHANNELS  = 2,
    parameter int OSR       = 64,
    parameter int ORDER     = 1,
    parameter int SIGNED_IN = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS*DATA_BITS-1:0] din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          enable,
    output logic [CHANNELS-1:0]           dout,
    output logic                          underrun
);

    localparam int VW    = CHANNELS * DATA_BITS;
    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
    localparam logic [DATA_BITS-1:0] MID = {1'b1, {(DATA_BITS-1){1'b0}}};
    // Silence: zero density for offset input, half density for signed input.
    localparam logic [VW-1:0] ACTIVE_RST = (SIGNED_IN != 0) ? {CHANNELS{MID}} : '0;

    // Two's complement to offset binary is a flip of each channel's MSB.
    function automatic logic [VW-1:0] to_offset(input logic [VW-1:0] x);
        logic [VW-1:0] y;
        y = x;
        if (SIGNED_IN != 0) begin
            for (int k = 0; k < CHANNELS; k++) begin
                y[k*DATA_BITS + DATA_BITS - 1] = ~x[k*DATA_BITS + DATA_BITS - 1];
            end
        end
        return y;
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic [VW-1:0]       hold_q, hold_d;
    logic [VW-1:0]       active_q, active_d;
    logic [CHANNELS-1:0] dout_q, dout_d;
    logic                boundary;
    logic                accept;

    // ---------------- frame counter and handshake ----------------
    always_comb begin
        boundary  = enable && (cnt_q == CNT_LAST);
        accept    = din_valid && !pending_q;
        cnt_d     = cnt_q + CNT_W'(1);
        hold_d    = hold_q;
        pending_d = pending_q;
        active_d  = active_q;
        if (!enable || boundary) begin
            cnt_d = '0;
        end
        // A boundary with a pending sample and an accept cannot coincide,
        // since accept requires pending_q == 0.
        if (boundary && pending_q) begin
            active_d  = hold_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            hold_d    = to_offset(din);
            pending_d = 1'b1;
        end
    end

    assign din_ready = !pending_q;
    assign underrun  = boundary && !pending_q;
    assign dout      = dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            hold_q    <= '0;
            active_q  <= ACTIVE_RST;
            dout_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            active_q  <= active_d;
            dout_q    <= dout_d;
        end
    end

    // ---------------- modulators ----------------
    if (ORDER == 1) begin : g_ord1
        logic [DATA_BITS-1:0] acc_q   [CHANNELS];
        logic [DATA_BITS-1:0] acc_d   [CHANNELS];
        logic [DATA_BITS:0]   acc_sum [CHANNELS];

        // The carry out of the accumulator is the output bit; only the low
        // bits are kept as state.
        always_comb begin
            dout_d = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                acc_sum[k] = {1'b0, acc_q[k]} + {1'b0, active_q[k*DATA_BITS +: DATA_BITS]};
                acc_d[k]   = '0;
                if (enable) begin
                    acc_d[k]  = acc_sum[k][DATA_BITS-1:0];
                    dout_d[k] = acc_sum[k][DATA_BITS];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < CHANNELS; k++) acc_q[k] <= '0;
            end else begin
                for (int k = 0; k < CHANNELS; k++) acc_q[k] <= acc_d[k];
            end
        end
    end else if (ORDER == 2) begin : g_ord2
        localparam int IW = DATA_BITS + 4;
        // Working width leaves headroom so sums of saturated terms never wrap.
        localparam int WW = DATA_BITS + 6;
        localparam logic signed [WW-1:0] HALF_W = WW'(2 ** (DATA_BITS - 1));
        localparam logic signed [WW-1:0] IMAX_W = WW'((2 ** (IW - 1)) - 1);
        localparam logic signed [WW-1:0] IMIN_W = -IMAX_W - WW'(1);

        function automatic logic signed [WW-1:0] sext(input logic signed [IW-1:0] x);
            return {{(WW-IW){x[IW-1]}}, x};
        endfunction

        function automatic logic signed [IW-1:0] sat(input logic signed [WW-1:0] x);
            if (x > IMAX_W) return {1'b0, {(IW-1){1'b1}}};
            if (x < IMIN_W) return {1'b1, {(IW-1){1'b0}}};
            return x[IW-1:0];
        endfunction

        logic signed [IW-1:0] i1_q [CHANNELS];
        logic signed [IW-1:0] i2_q [CHANNELS];
        logic signed [IW-1:0] i1_d [CHANNELS];
        logic signed [IW-1:0] i2_d [CHANNELS];
        logic signed [IW-1:0] i1n  [CHANNELS];
        logic signed [IW-1:0] i2n  [CHANNELS];
        logic signed [WW-1:0] xc   [CHANNELS];
        logic signed [WW-1:0] fb   [CHANNELS];

        always_comb begin
            dout_d = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                xc[k]  = $signed({{(WW-DATA_BITS){1'b0}}, active_q[k*DATA_BITS +: DATA_BITS]}) - HALF_W;
                fb[k]  = dout_q[k] ? HALF_W : -HALF_W;
                i1n[k] = sat(sext(i1_q[k]) + xc[k] - fb[k]);
                i2n[k] = sat(sext(i2_q[k]) + sext(i1n[k]) - fb[k]);
                i1_d[k] = '0;
                i2_d[k] = '0;
                if (enable) begin
                    i1_d[k]   = i1n[k];
                    i2_d[k]   = i2n[k];
                    dout_d[k] = !i2n[k][IW-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    i1_q[k] <= '0;
                    i2_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k < CHANNELS; k++) begin
                    i1_q[k] <= i1_d[k];
                    i2_q[k] <= i2_d[k];
                end
            end
        end
    end else begin : g_bad_order
        $error("pdm_dac_mc: ORDER must be 1 or 2");
    end

endmodule
